// File: rtl/fft_pkg.sv
// Shared definitions for the SDF FFT pipeline stages.
//   state_t   : control-unit state encoding driven into every butterfly stage
//   *_DEF     : default component widths for samples, twiddles and outputs
//   sat_round : round-half-up then saturate, used after every twiddle multiply
package fft_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'b00,
        ST_FIRST   = 2'b01,
        ST_SECOND  = 2'b10,
        ST_WAITING = 2'b11
    } state_t;

    localparam int DW_DEF    = 8;   // sample component, Q5.3
    localparam int WW_DEF    = 8;   // twiddle component, Q2.6
    localparam int WFRAC_DEF = 6;   // twiddle fractional bits
    localparam int OW_DEF    = 9;   // output component, Q6.3

    // Adds half an LSB of the target scale, shifts arithmetically by wfrac,
    // then clamps to the signed range of an ow-bit result.
    function automatic logic signed [31:0] sat_round(input logic signed [31:0] p,
                                                     input int wfrac,
                                                     input int ow);
        logic signed [31:0] half;
        logic signed [31:0] r;
        logic signed [31:0] hi;
        logic signed [31:0] lo;
        half = 32'sd1 <<< (wfrac - 1);
        r    = (p + half) >>> wfrac;
        hi   = (32'sd1 <<< (ow - 1)) - 32'sd1;
        lo   = -(32'sd1 <<< (ow - 1));
        if (r > hi)
            return hi;
        else if (r < lo)
            return lo;
        return r;
    endfunction

endpackage

// File: rtl/sdf_delay_line.sv
// Circular feedback buffer for an SDF stage.
//   clk  : rising-edge clock
//   rst  : synchronous active-high reset, clears every entry and the pointer
//   en   : advance - write din at the pointer and step the pointer
//   din  : entry written this cycle
//   dout : head of the buffer, i.e. the entry written DEPTH advances ago
module sdf_delay_line #(
    parameter int DEPTH = 16,
    parameter int W     = 18
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         en,
    input  logic [W-1:0] din,
    output logic [W-1:0] dout
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] ptr;

    // The slot about to be overwritten is the oldest one, so it is the head.
    assign dout = mem[ptr];

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++)
                mem[i] <= '0;
            ptr <= '0;
        end else if (en) begin
            mem[ptr] <= din;
            ptr      <= (ptr == AW'(DEPTH - 1)) ? '0 : ptr + AW'(1);
        end
    end

endmodule

// File: rtl/sdf_bfly16.sv
// First radix-2 SDF butterfly of the 32-point FFT.
//   clk, rst             : clock, synchronous active-high reset
//   state                : control state (IDLE/FIRST/SECOND/WAITING)
//   data_in_r/_i         : incoming sample, cycle-aligned with state
//   WN_r/_i              : twiddle, meaningful only in SECOND
//   valid_o              : data_out_* carries a result from the previous edge
//   data_out_r/_i        : serial stream g (FIRST) then h*WN (SECOND)
//   seq_err              : sticky flag, FIRST began before the buffer was full
module sdf_bfly16
    import fft_pkg::*;
#(
    parameter int DW    = DW_DEF,
    parameter int WW    = WW_DEF,
    parameter int WFRAC = WFRAC_DEF,
    parameter int DEPTH = 16,
    parameter int OW    = DW + 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [1:0]           state,
    input  logic [DW-1:0]        data_in_r,
    input  logic [DW-1:0]        data_in_i,
    input  logic [WW-1:0]        WN_r,
    input  logic [WW-1:0]        WN_i,
    output logic                 valid_o,
    output logic signed [OW-1:0] data_out_r,
    output logic signed [OW-1:0] data_out_i,
    output logic                 seq_err
);

    localparam int PW = OW + WW + 1;          // full complex-product width
    localparam int CW = $clog2(DEPTH + 1);

    state_t               st;
    logic                 adv;
    logic [2*OW-1:0]      head;
    logic [2*OW-1:0]      wr_data;
    logic signed [OW-1:0] a_r, a_i, b_r, b_i;
    logic signed [OW-1:0] g_r, g_i, h_r, h_i;
    logic signed [OW-1:0] m_r, m_i;
    logic signed [PW-1:0] ar_x, ai_x, wr_x, wi_x;
    logic signed [PW-1:0] p_r, p_i;
    logic [CW-1:0]        fill_cnt;

    assign st  = state_t'(state);
    assign adv = (st != ST_IDLE);

    sdf_delay_line #(
        .DEPTH (DEPTH),
        .W     (2 * OW)
    ) u_dl (
        .clk  (clk),
        .rst  (rst),
        .en   (adv),
        .din  (wr_data),
        .dout (head)
    );

    assign a_r = head[2*OW-1:OW];
    assign a_i = head[OW-1:0];
    assign b_r = {{(OW-DW){data_in_r[DW-1]}}, data_in_r};
    assign b_i = {{(OW-DW){data_in_i[DW-1]}}, data_in_i};

    // Buffered samples are at most DW bits wide, so the sum and difference fit OW.
    assign g_r = a_r + b_r;
    assign g_i = a_i + b_i;
    assign h_r = a_r - b_r;
    assign h_i = a_i - b_i;

    assign ar_x = {{(PW-OW){a_r[OW-1]}}, a_r};
    assign ai_x = {{(PW-OW){a_i[OW-1]}}, a_i};
    assign wr_x = {{(PW-WW){WN_r[WW-1]}}, WN_r};
    assign wi_x = {{(PW-WW){WN_i[WW-1]}}, WN_i};

    assign p_r = ar_x * wr_x - ai_x * wi_x;
    assign p_i = ar_x * wi_x + ai_x * wr_x;

    assign m_r = OW'(sat_round({{(32-PW){p_r[PW-1]}}, p_r}, WFRAC, OW));
    assign m_i = OW'(sat_round({{(32-PW){p_i[PW-1]}}, p_i}, WFRAC, OW));

    // SECOND writes zeros so a following WAITING refills from a clean buffer.
    always_comb begin
        wr_data = '0;
        case (st)
            ST_WAITING: wr_data = {b_r, b_i};
            ST_FIRST:   wr_data = {h_r, h_i};
            default:    wr_data = '0;
        endcase
    end

    // Output register stage: result of the state sampled on this edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            valid_o    <= 1'b0;
            data_out_r <= '0;
            data_out_i <= '0;
            fill_cnt   <= '0;
            seq_err    <= 1'b0;
        end else begin
            valid_o <= (st == ST_FIRST) || (st == ST_SECOND);
            case (st)
                ST_WAITING: begin
                    if (fill_cnt < CW'(DEPTH))
                        fill_cnt <= fill_cnt + CW'(1);
                end
                ST_FIRST: begin
                    data_out_r <= g_r;
                    data_out_i <= g_i;
                    if (fill_cnt < CW'(DEPTH))
                        seq_err <= 1'b1;
                end
                ST_SECOND: begin
                    data_out_r <= m_r;
                    data_out_i <= m_i;
                    // Cleared here so a back-to-back WAITING counts from zero.
                    fill_cnt   <= '0;
                end
                default: fill_cnt <= '0;
            endcase
        end
    end

endmodule

// File: tb/tb_sdf_bfly16.sv
module tb_sdf_bfly16;

    localparam logic [1:0] IDLE    = 2'b00;
    localparam logic [1:0] FIRST   = 2'b01;
    localparam logic [1:0] SECOND  = 2'b10;
    localparam logic [1:0] WAITING = 2'b11;

    logic              clk = 1'b0;
    logic              rst;
    logic [1:0]        state;
    logic [7:0]        data_in_r, data_in_i;
    logic [7:0]        WN_r, WN_i;
    logic              valid_o;
    logic signed [8:0] data_out_r, data_out_i;
    logic              seq_err;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    sdf_bfly16 dut (
        .clk        (clk),
        .rst        (rst),
        .state      (state),
        .data_in_r  (data_in_r),
        .data_in_i  (data_in_i),
        .WN_r       (WN_r),
        .WN_i       (WN_i),
        .valid_o    (valid_o),
        .data_out_r (data_out_r),
        .data_out_i (data_out_i),
        .seq_err    (seq_err)
    );

    task automatic chk(input string tag, input logic signed [31:0] obs,
                       input logic signed [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Apply one cycle of inputs, then settle just past the rising edge.
    task automatic drive(input logic [1:0] st, input int dr, input int di,
                         input int wr, input int wi);
        state     = st;
        data_in_r = dr[7:0];
        data_in_i = di[7:0];
        WN_r      = wr[7:0];
        WN_i      = wi[7:0];
        @(posedge clk);
        #1;
    endtask

    task automatic chk_out(input string tag, input int er, input int ei);
        chk({tag, "_r"}, 32'(data_out_r), er);
        chk({tag, "_i"}, 32'(data_out_i), ei);
    endtask

    initial begin
        rst = 1'b1;
        drive(FIRST, 3, 3, 0, 0);
        drive(FIRST, 3, 3, 0, 0);
        chk("rst_valid", 32'(valid_o), 0);
        chk_out("rst_out", 0, 0);
        chk("rst_seq_err", 32'(seq_err), 0);
        rst = 1'b0;

        // Frame 1: sum path and twiddle path
        for (int k = 0; k < 16; k++) drive(WAITING, k, 0, 0, 0);
        chk("fill_valid", 32'(valid_o), 0);
        for (int k = 0; k < 16; k++) begin
            drive(FIRST, 16 + k, 0, 0, 0);
            chk("g1_valid", 32'(valid_o), 1);
            chk_out("g1", 2 * k + 16, 0);
        end
        chk("f1_seq_err", 32'(seq_err), 0);
        drive(SECOND, 0, 0, 8'h40, 8'h00);
        chk("h_w0_valid", 32'(valid_o), 1);
        chk_out("h_w0", -16, 0);
        drive(SECOND, 0, 0, 8'h00, 8'hC0);
        chk_out("h_mj", 0, 16);
        // (-16)*45 = -720 -> -11 ; (-16)*(-46) = 736 -> 11.5 rounds up to 12
        drive(SECOND, 0, 0, 8'h2D, 8'hD2);
        chk_out("h_w45", -11, 12);
        for (int k = 0; k < 13; k++) drive(SECOND, 0, 0, 8'h40, 8'h00);
        chk_out("h_last", -16, 0);

        // Frame 2, back-to-back: saturation
        drive(WAITING, 127, 127, 0, 0);
        chk("hold_valid", 32'(valid_o), 0);
        chk_out("hold", -16, 0);
        for (int k = 0; k < 15; k++) drive(WAITING, 127, 127, 0, 0);
        drive(FIRST, -128, -128, 0, 0);
        chk_out("g2", -1, -1);
        for (int k = 0; k < 15; k++) drive(FIRST, -128, -128, 0, 0);
        drive(SECOND, 0, 0, 8'h40, 8'hC0);
        chk_out("sat_pos", 255, 0);
        drive(SECOND, 0, 0, 8'hC0, 8'h40);
        chk_out("sat_neg", -256, 0);
        for (int k = 0; k < 14; k++) drive(SECOND, 0, 0, 0, 0);
        chk_out("sat_zero", 0, 0);
        chk("f2_seq_err", 32'(seq_err), 0);

        // Frame 3, back-to-back: must match frame 1
        for (int k = 0; k < 16; k++) drive(WAITING, k, 0, 0, 0);
        for (int k = 0; k < 16; k++) begin
            drive(FIRST, 16 + k, 0, 0, 0);
            chk_out("g3", 2 * k + 16, 0);
        end
        chk("f3_seq_err", 32'(seq_err), 0);
        for (int k = 0; k < 3; k++) drive(SECOND, 0, 0, 8'h40, 8'h00);
        chk_out("h3", -16, 0);

        // Reset mid-SECOND, then resume in FIRST without WAITING
        rst = 1'b1;
        drive(SECOND, 0, 0, 8'h40, 8'h00);
        chk("mid_rst_valid", 32'(valid_o), 0);
        chk_out("mid_rst", 0, 0);
        chk("mid_rst_seq_err", 32'(seq_err), 0);
        rst = 1'b0;
        drive(FIRST, 5, 0, 0, 0);
        chk("resume_valid", 32'(valid_o), 1);
        chk_out("resume", 5, 0);
        chk("resume_seq_err", 32'(seq_err), 1);

        // Short fill then FIRST
        rst = 1'b1;
        drive(IDLE, 0, 0, 0, 0);
        rst = 1'b0;
        drive(IDLE, 0, 0, 0, 0);
        for (int k = 0; k < 5; k++) drive(WAITING, 1, 1, 0, 0);
        chk("short_pre", 32'(seq_err), 0);
        drive(FIRST, 2, 2, 0, 0);
        chk("short_set", 32'(seq_err), 1);
        chk_out("short_g", 2, 2);
        for (int k = 0; k < 3; k++) drive(IDLE, 0, 0, 0, 0);
        chk("short_sticky", 32'(seq_err), 1);
        chk("idle_valid", 32'(valid_o), 0);
        rst = 1'b1;
        drive(IDLE, 0, 0, 0, 0);
        chk("short_clear", 32'(seq_err), 0);
        rst = 1'b0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
